demux_1_8_scheduler: RTL and testbench

Sequencing controller for the 1-to-8 demultiplexer datapath. It accepts a serial bit stream on a valid/ready handshake and chooses a destination lane for each bit, either round-robin over enabled lanes or a fixed configured lane. It drives the demux select `s` and holds each bit on a one-hot lane valid until that lane's consumer accepts it. Lanes that stall too long are retired from rotation until they recover.

---
 rtl/demux_sched_pkg.sv | 34 +++
 rtl/demux_rr_pick.sv | 27 ++
 rtl/demux_1_8_scheduler.sv | 124 ++++++++++++
 tb/tb_demux_1_8_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared constants, state type and round-robin helper for the demux scheduler
package demux_sched_pkg;

    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        RETRY = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] lane;
    } pick_t;

    // First set bit of mask strictly after ptr, wrapping; ptr itself has lowest priority.
    function automatic pick_t rr_next(input logic [SEL_W-1:0] ptr, input logic [N_OUT-1:0] mask);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        // Walk from farthest to nearest so the nearest eligible lane is the one left in res.
        for (int i = N_OUT; i >= 1; i--) begin
            idx = ptr + SEL_W'(i);
            if (mask[idx]) begin
                res.found = 1'b1;
                res.lane  = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// rtl/demux_rr_pick.sv - combinational lane picker (rotate priority or fixed lane)
module demux_rr_pick
    import demux_sched_pkg::*;
(
    input  logic [N_OUT-1:0] elig,
    input  logic [SEL_W-1:0] last_grant,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_cfg,
    output logic             found,
    output logic [SEL_W-1:0] lane
);

    pick_t rr_res;

    assign rr_res = rr_next(last_grant, elig);

    // Fixed mode only ever offers sel_cfg; rotation mode takes the next eligible lane after the last grant.
    always_comb begin
        found = rr_res.found;
        lane  = rr_res.lane;
        if (mode) begin
            found = elig[sel_cfg];
            lane  = sel_cfg;
        end
    end

endmodule

// File: rtl/demux_1_8_scheduler.sv
// rtl/demux_1_8_scheduler.sv - 1-to-8 demux sequencer with per-lane stall retirement
module demux_1_8_scheduler
    import demux_sched_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    input  logic [N_OUT-1:0] en_mask,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_cfg,
    input  logic [N_OUT-1:0] out_ready,
    output logic [SEL_W-1:0] s,
    output logic [N_OUT-1:0] y,
    output logic [N_OUT-1:0] y_valid,
    output logic [N_OUT-1:0] stall_mask,
    output logic             timeout_pulse
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic              held;
    logic [7:0]        wait_cnt;
    logic [SEL_W-1:0]  last_grant;
    logic [N_OUT-1:0]  elig;
    logic              found;
    logic [SEL_W-1:0]  lane;
    logic [N_OUT-1:0]  sel_onehot;
    logic              lane_rdy;
    logic              tmo;

    assign elig       = en_mask & ~stall_mask;
    assign sel_onehot = N_OUT'(1) << s;
    assign lane_rdy   = out_ready[s];
    // A handshake in the timeout cycle wins, so the timeout needs the lane to still be stalling.
    assign tmo        = (state == HOLD) && !lane_rdy && (wait_cnt == TIMEOUT_W);

    demux_rr_pick u_pick (
        .elig       (elig),
        .last_grant (last_grant),
        .mode       (mode),
        .sel_cfg    (sel_cfg),
        .found      (found),
        .lane       (lane)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && found) state_nxt = HOLD;
            HOLD: begin
                if (lane_rdy) begin
                    state_nxt = IDLE;
                end else if (tmo) begin
                    state_nxt = RETRY;
                end
            end
            RETRY:   if (found) state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the held bit is only offered on lane s while in HOLD; in_ready is masked during reset.
    always_comb begin
        in_ready = rst_n && (state == IDLE) && found;
        y_valid  = (state == HOLD) ? sel_onehot : '0;
        y        = y_valid & {N_OUT{held}};
    end

    // Datapath: select, held bit, wait counter, rotation pointer and stall bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s             <= '0;
            held          <= 1'b0;
            wait_cnt      <= '0;
            last_grant    <= '1;
            stall_mask    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= tmo;
            // Any ready lane recovers; a timeout on the same lane in the same cycle takes precedence.
            stall_mask    <= (stall_mask & ~out_ready) | (tmo ? sel_onehot : '0);
            case (state)
                IDLE: begin
                    if (in_valid && found) begin
                        held     <= in_data;
                        s        <= lane;
                        wait_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (lane_rdy) begin
                        last_grant <= s;
                    end else if (!tmo) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RETRY: begin
                    if (found) begin
                        s        <= lane;
                        wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1_8_scheduler.sv
// tb/tb_demux_1_8_scheduler.sv - scoreboard bench for the 1-to-8 demux scheduler
module tb_demux_1_8_scheduler;

    localparam int TO = 15;

    typedef struct packed {
        logic       found;
        logic [2:0] lane;
    } pick_r;

    typedef struct {
        logic [2:0] lane;
        logic       b;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic [7:0] en_mask;
    logic       mode;
    logic [2:0] sel_cfg;
    logic [7:0] out_ready;
    logic [2:0] s;
    logic [7:0] y;
    logic [7:0] y_valid;
    logic [7:0] stall_mask;
    logic       timeout_pulse;

    int checks   = 0;
    int failures = 0;

    item_t q[$];

    // reference model state
    logic       m_busy  = 0;
    logic       m_retry = 0;
    logic [2:0] m_lane  = 0;
    logic       m_bit   = 0;
    int         m_wait  = 0;
    int         m_last  = 7;
    logic [7:0] m_stall = 0;
    logic       exp_pulse = 0;

    demux_1_8_scheduler #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .en_mask       (en_mask),
        .mode          (mode),
        .sel_cfg       (sel_cfg),
        .out_ready     (out_ready),
        .s             (s),
        .y             (y),
        .y_valid       (y_valid),
        .stall_mask    (stall_mask),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pick_r tb_pick(input int last, input logic [7:0] elig, input logic md, input int sel);
        pick_r r;
        r = '0;
        if (md) begin
            r.found = elig[sel];
            r.lane  = 3'(sel);
            return r;
        end
        for (int k = 1; k <= 8; k++) begin
            int l;
            l = (last + k) % 8;
            if (elig[l]) begin
                r.found = 1'b1;
                r.lane  = 3'(l);
                return r;
            end
        end
        return r;
    endfunction

    // Monitor: compare outputs with the model every cycle, pop the scoreboard on each lane handshake.
    always @(negedge clk) begin
        pick_r      p;
        logic [7:0] exp_yv;
        logic [7:0] set_v;
        item_t      it;
        if (!rst_n) begin
            check("rst_y_valid", y_valid, 8'h00);
            check("rst_in_ready", in_ready, 1'b0);
            m_busy = 0; m_retry = 0; m_wait = 0; m_last = 7; m_stall = 0; exp_pulse = 0;
            q.delete();
        end else begin
            p      = tb_pick(m_last, en_mask & ~m_stall, mode, sel_cfg);
            exp_yv = (m_busy && !m_retry) ? (8'h01 << m_lane) : 8'h00;
            check("y_valid", y_valid, exp_yv);
            check("y", y, m_bit ? exp_yv : 8'h00);
            if (m_busy && !m_retry) check("s", s, m_lane);
            check("in_ready", in_ready, !m_busy && p.found);
            check("stall_mask", stall_mask, m_stall);
            check("timeout_pulse", timeout_pulse, exp_pulse);
            set_v     = 8'h00;
            exp_pulse = 0;
            if (m_busy && !m_retry) begin
                if (out_ready[m_lane]) begin
                    if (q.size() == 0) begin
                        check("sb_underflow", q.size(), 1);
                    end else begin
                        it = q.pop_front();
                        check("sb_lane", s, it.lane);
                        check("sb_y", y, it.b ? (8'h01 << it.lane) : 8'h00);
                    end
                    m_last = m_lane;
                    m_busy = 0;
                end else if (m_wait == TO) begin
                    set_v     = 8'h01 << m_lane;
                    exp_pulse = 1;
                    m_retry   = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_busy) begin
                if (p.found) begin
                    m_lane  = p.lane;
                    m_retry = 0;
                    m_wait  = 0;
                end
            end else if (in_valid && p.found) begin
                m_busy = 1;
                m_lane = p.lane;
                m_bit  = in_data;
                m_wait = 0;
            end
            m_stall = (m_stall & ~out_ready) | set_v;
        end
    end

    // Called and returns at posedge+1.
    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", m_busy, 1'b0);
    endtask

    task automatic send(input logic b, input logic [2:0] lane);
        item_t it;
        wait_idle();
        in_valid = 1;
        in_data  = b;
        it.lane  = lane;
        it.b     = b;
        q.push_back(it);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic seen;
        int low_cnt[8];
        pick_r p;
        item_t it;

        rst_n = 0; in_valid = 0; in_data = 0; en_mask = 8'hFF; mode = 0; sel_cfg = 0; out_ready = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s", s, 3'd0);
        check("reset_y", y, 8'h00);
        check("reset_y_valid", y_valid, 8'h00);
        check("reset_stall", stall_mask, 8'h00);
        check("reset_pulse", timeout_pulse, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        rst_n = 1;

        // round-robin over all lanes
        out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) send(1'b1, 3'(i));
        wait_idle();

        // timeout on lane 0, retry on lane 1, then recovery
        out_ready = 8'hFE;
        send(1'b1, 3'd1);
        cyc = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (timeout_pulse) begin
                seen = 1;
                break;
            end
        end
        check("tmo_seen", seen, 1'b1);
        check("tmo_latency", cyc, TO + 2);
        check("tmo_stall", stall_mask, 8'h01);
        @(posedge clk);
        #1;
        wait_idle();
        check("stall_kept", stall_mask, 8'h01);
        out_ready = 8'hFF;
        @(posedge clk);
        #1;
        check("stall_cleared", stall_mask, 8'h00);

        // sparse mask with wrap
        en_mask = 8'b1010_0100;
        send(1'b1, 3'd2); send(1'b0, 3'd5); send(1'b1, 3'd7); send(1'b1, 3'd2);
        wait_idle();
        en_mask = 8'hFF;

        // fixed lane
        mode = 1; sel_cfg = 3'd3;
        send(1'b1, 3'd3); send(1'b0, 3'd3); send(1'b1, 3'd3);
        wait_idle();
        en_mask = 8'hF7; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("fixed_masked_in_ready", in_ready, 1'b0);
        end
        in_valid = 0; en_mask = 8'hFF; mode = 0;

        // handshake exactly at wait_cnt == TIMEOUT
        out_ready = 8'h00;
        send(1'b1, 3'd4);
        repeat (TO) @(posedge clk);
        #1;
        out_ready = 8'hFF;
        @(posedge clk);
        #1;
        check("boundary_pulse", timeout_pulse, 1'b0);
        check("boundary_stall", stall_mask, 8'h00);
        check("boundary_done", m_busy, 1'b0);

        // async reset mid-HOLD
        out_ready = 8'h00;
        send(1'b1, 3'd5);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("arst_y_valid", y_valid, 8'h00);
        check("arst_y", y, 8'h00);
        check("arst_s", s, 3'd0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_stall", stall_mask, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 8'hFF;
        send(1'b1, 3'd0);
        wait_idle();

        // randomized traffic; no lane is held off long enough to time out
        for (int i = 0; i < 8; i++) low_cnt[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 8; i++) begin
                logic r;
                r = 1'($urandom_range(0, 1));
                if (low_cnt[i] >= 6) r = 1;
                out_ready[i] = r;
                low_cnt[i] = r ? 0 : low_cnt[i] + 1;
            end
            en_mask = 8'($urandom_range(1, 255));
            mode    = ($urandom_range(0, 3) == 0);
            sel_cfg = 3'($urandom_range(0, 7));
            in_valid = 0;
            if (!m_busy && $urandom_range(0, 1) == 1) begin
                in_valid = 1;
                in_data  = 1'($urandom_range(0, 1));
                p = tb_pick(m_last, en_mask & ~m_stall, mode, 32'(sel_cfg));
                if (p.found) begin
                    it.lane = p.lane;
                    it.b    = in_data;
                    q.push_back(it);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        out_ready = 8'hFF;
        wait_idle();
        @(posedge clk);
        #1;
        check("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
